// File: rtl/regfile_pkg.sv
// Shared constants, opcode map, FSM states and decode helper
// for the register file issue controller.
package regfile_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_R32  = 7'b0111011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_I32  = 7'b0011011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CHECK,
    OUT
  } state_e;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] op);
    dec_t d;
    d = '0;
    case (op)
      OP_R, OP_R32:                 d = 3'b111;
      OP_I, OP_I32, OP_LD, OP_JALR: d = 3'b101;
      OP_ST, OP_BR:                 d = 3'b110;
      OP_LUI, OP_AUI, OP_JAL:       d = 3'b001;
      default:                      d = 3'b000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write busy bits; a set on the same index as a clear
// wins because the issuing writer is younger than the retiring one.
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  output logic [NREG-1:0] busy
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_issue_ctrl.sv
// Decode-side issue controller: reads operands, blocks RAW/WAW
// hazards against the busy scoreboard and relays writeback.
module regfile_issue_ctrl
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [AW-1:0]   rf_rs1_addr,
  output logic [AW-1:0]   rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [AW-1:0]   rf_wr_addr,
  output logic [XLEN-1:0] rf_wr_data,
  output logic            rf_regWr,
  output logic [NREG-1:0] busy
);

  state_e          state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;

  dec_t          dec;
  logic [AW-1:0] rs1, rs2, rd;
  logic          need1, need2, need_rd;
  logic          fwd1, fwd2, fwd_rd;
  logic          haz1, haz2, haz_rd, hazard;
  logic          issue, set_en, clr_en;

  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];
  assign rd  = instr_q[11:7];

  always_comb begin
    dec     = decode(instr_q[6:0]);
    need1   = dec.uses_rs1 && (rs1 != '0);
    need2   = dec.uses_rs2 && (rs2 != '0);
    need_rd = dec.writes_rd && (rd != '0);
    fwd1    = wb_valid && (wb_rd == rs1);
    fwd2    = wb_valid && (wb_rd == rs2);
    fwd_rd  = wb_valid && (wb_rd == rd);
    haz1    = need1 && busy[rs1] && !fwd1;
    haz2    = need2 && busy[rs2] && !fwd2;
    haz_rd  = need_rd && busy[rd] && !fwd_rd;
    hazard  = haz1 || haz2 || haz_rd;
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          instr_d = in_instr;
          state_d = READ;
        end
      end
      READ: state_d = CHECK;
      CHECK: begin
        if (!hazard) begin
          issue   = 1'b1;
          rs1_d   = !need1 ? '0 :
                    fwd1   ? wb_data : rf_rs1_data;
          rs2_d   = !need2 ? '0 :
                    fwd2   ? wb_data : rf_rs2_data;
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      instr_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign set_en = issue && need_rd;
  assign clr_en = wb_valid && (wb_rd != '0);

  reg_scoreboard u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (set_en),
    .set_idx (rd),
    .clr_en  (clr_en),
    .clr_idx (wb_rd),
    .busy    (busy)
  );

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == OUT);
  assign out_instr    = instr_q;
  assign out_rs1_data = rs1_q;
  assign out_rs2_data = rs2_q;
  assign rf_rs1_addr  = rs1;
  assign rf_rs2_addr  = rs2;
  assign rf_wr_addr   = wb_rd;
  assign rf_wr_data   = wb_data;
  assign rf_regWr     = clr_en;

endmodule

// File: tb/tb_regfile_issue_ctrl.sv
// Scoreboard bench for regfile_issue_ctrl with a behavioural
// register file hooked to the read and write ports.
module tb_regfile_issue_ctrl;
  import regfile_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready;
  logic [31:0]     in_instr;
  logic            out_valid, out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_rs1_data, out_rs2_data;
  logic [AW-1:0]   rf_rs1_addr, rf_rs2_addr;
  logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [AW-1:0]   rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
  logic            rf_regWr;
  logic [NREG-1:0] busy;

  regfile_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_regWr(rf_regWr), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] rf [NREG];
  initial for (int i = 0; i < NREG; i++) rf[i] = '0;
  assign rf_rs1_data = (rf_rs1_addr == '0) ? '0 : rf[rf_rs1_addr];
  assign rf_rs2_data = (rf_rs2_addr == '0) ? '0 : rf[rf_rs2_addr];
  always @(posedge clk) if (rf_regWr) rf[rf_wr_addr] <= rf_wr_data;

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  logic [NREG-1:0] exp_busy;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  // Monitor: every accepted output bundle is matched against the queue
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 64'(out_instr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_instr", 64'(out_instr), 64'(e.instr));
        chk("out_rs1", out_rs1_data, e.a);
        chk("out_rs2", out_rs2_data, e.b);
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rd,
      input logic [4:0] s1, input logic [4:0] s2, input logic [6:0] op);
    return {7'b0, s2, s1, 3'b000, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] rd,
      input logic [4:0] s1, input logic [11:0] imm, input logic [6:0] op);
    return {imm, s1, 3'b000, rd, op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [4:0] rd,
      input logic [6:0] op);
    return {20'h12345, rd, op};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] ins);
    in_instr = ins;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm, output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      cyc();
      n++;
    end
    if (!out_valid) chk({nm, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic issue(input string nm, input logic [31:0] ins,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int n;
    exp_q.push_back('{ins, a, b});
    accept(ins);
    wait_out(nm, n);
    chk({nm, "_latency"}, 64'(n), 64'(2));
    cyc();
  endtask

  task automatic wb(input logic [4:0] r, input logic [XLEN-1:0] d);
    wb_valid = 1'b1;
    wb_rd    = r;
    wb_data  = d;
  endtask

  initial begin
    int n;
    logic [31:0] ins;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_regwr", 64'(rf_regWr), 64'(0));
    chk("rst_rs1_addr", 64'(rf_rs1_addr), 64'(0));

    // writeback to a non-busy register
    wb(5'd5, 64'hAAAA);
    #1;
    chk("wb_regwr", 64'(rf_regWr), 64'(1));
    chk("wb_addr", 64'(rf_wr_addr), 64'(5));
    cyc();
    wb(5'd1, 64'h1111);
    cyc();
    wb_valid = 1'b0;
    exp_busy = '0;
    chk("wb_busy_unchanged", 64'(busy), 64'(exp_busy));

    issue("add", enc_r(5'd3, 5'd5, 5'd6, OP_R), 64'hAAAA, 64'h0);
    exp_busy[3] = 1'b1;
    chk("add_busy", 64'(busy), 64'(exp_busy));

    // RAW stall on x5, released by forwarded writeback
    issue("lui5", enc_u(5'd5, OP_LUI), 64'h0, 64'h0);
    exp_busy[5] = 1'b1;
    chk("lui5_busy", 64'(busy), 64'(exp_busy));
    ins = enc_i(5'd7, 5'd5, 12'd1, OP_I);
    exp_q.push_back('{ins, 64'h1234, 64'h0});
    accept(ins);
    cyc(); cyc(); cyc();
    chk("raw_stall_valid", 64'(out_valid), 64'(0));
    chk("raw_stall_ready", 64'(in_ready), 64'(0));
    wb(5'd5, 64'h1234);
    cyc();
    wb_valid = 1'b0;
    chk("raw_out_valid", 64'(out_valid), 64'(1));
    exp_busy[5] = 1'b0;
    exp_busy[7] = 1'b1;
    chk("raw_busy", 64'(busy), 64'(exp_busy));
    cyc();

    // x0 destination and source with a stray x0 writeback
    issue("lui0", enc_u(5'd0, OP_LUI), 64'h0, 64'h0);
    chk("lui0_busy", 64'(busy), 64'(exp_busy));
    wb(5'd0, 64'hDEAD);
    #1;
    chk("wb_x0_regwr", 64'(rf_regWr), 64'(0));
    issue("addi_x0", enc_i(5'd2, 5'd0, 12'd5, OP_I), 64'h0, 64'h0);
    wb_valid = 1'b0;
    exp_busy[2] = 1'b1;
    chk("addi_x0_busy", 64'(busy), 64'(exp_busy));

    // WAW on x4 with colliding clear and set
    issue("lui4", enc_u(5'd4, OP_LUI), 64'h0, 64'h0);
    exp_busy[4] = 1'b1;
    ins = enc_i(5'd4, 5'd1, 12'd0, OP_I);
    exp_q.push_back('{ins, 64'h1111, 64'h0});
    accept(ins);
    cyc(); cyc();
    chk("waw_stall_valid", 64'(out_valid), 64'(0));
    wb(5'd4, 64'h44);
    cyc();
    wb_valid = 1'b0;
    chk("waw_out_valid", 64'(out_valid), 64'(1));
    chk("waw_busy", 64'(busy), 64'(exp_busy));
    cyc();

    // reset while stalled on x4
    accept(enc_i(5'd9, 5'd4, 12'd0, OP_I));
    cyc(); cyc(); cyc();
    chk("stall2_valid", 64'(out_valid), 64'(0));
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rst_stall_valid", 64'(out_valid), 64'(0));
    chk("rst_stall_busy", 64'(busy), 64'(0));
    chk("rst_stall_ready", 64'(in_ready), 64'(1));

    // reset while holding OUT under backpressure
    out_ready = 1'b0;
    ins = enc_i(5'd10, 5'd1, 12'd0, OP_I);
    accept(ins);
    wait_out("bp", n);
    cyc(); cyc();
    chk("bp_hold_valid", 64'(out_valid), 64'(1));
    chk("bp_hold_instr", 64'(out_instr), 64'(ins));
    chk("bp_hold_rs1", out_rs1_data, 64'h1111);
    chk("bp_busy", 64'(busy), 64'(1 << 10));
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("rst_out_valid2", 64'(out_valid), 64'(0));
    chk("rst_out_busy2", 64'(busy), 64'(0));
    chk("rst_out_ready2", 64'(in_ready), 64'(1));
    cyc(); cyc();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
